// File: rtl/boot_image_loader_if.sv
// Byte-stream input and SRAM write-port signals of the boot image loader.
// master = loader side, slave = host link / SRAM side.
interface boot_image_loader_if #(
  parameter int ADDR_W = 12
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_image_loader.sv
// Fills the instruction SRAM from a little-endian byte stream (word count N,
// then N words) and keeps the core in reset until the whole image is written.
module boot_image_loader #(
  parameter int                ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int                DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  boot_image_loader_if.master bus,
  output logic                core_rst_n,
  output logic                load_done,
  output logic                load_err
);

  localparam int          CNT_W     = $clog2(DEPTH + 1);
  localparam logic [31:0] MAX_WORDS = 32'(DEPTH) - 32'(BASE);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_WR, S_DONE} state_e;

  state_e            state_q,    state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q,    shift_d;
  logic [CNT_W-1:0]  n_q,        n_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q,  mem_req_d;
  logic              in_ready_q, in_ready_d;
  logic              load_err_q, load_err_d;
  logic              done_q,     done_d;

  logic        take;
  logic        last_byte;
  logic [31:0] word_in;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    load_err_d = load_err_q;

    take      = bus.in_valid && in_ready_q;
    word_in   = {bus.in_data, shift_q[31:8]};
    last_byte = take && (byte_cnt_q == 2'd3);

    if (take) begin
      shift_d    = word_in;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    unique case (state_q)
      S_HDR: begin
        if (last_byte) begin
          if (word_in == 32'd0) begin
            state_d = S_DONE;
          end else if (word_in > MAX_WORDS) begin
            // Oversized image: flag it and load only what fits.
            load_err_d = 1'b1;
            n_d        = CNT_W'(MAX_WORDS);
            state_d    = S_DATA;
          end else begin
            n_d     = CNT_W'(word_in);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        if (bus.mem_ready) begin
          mem_req_d  = 1'b0;
          addr_d     = addr_q + ADDR_W'(1);
          word_cnt_d = word_cnt_q + CNT_W'(1);
          state_d    = (word_cnt_q + CNT_W'(1) == n_q) ? S_DONE : S_DATA;
        end
      end
      S_DONE: ;
    endcase

    // Restart wins over everything above, including a pending write.
    if (restart) begin
      state_d    = S_HDR;
      byte_cnt_d = 2'd0;
      shift_d    = 32'd0;
      n_d        = '0;
      word_cnt_d = '0;
      addr_d     = BASE;
      mem_addr_d = BASE;
      mem_req_d  = 1'b0;
      load_err_d = 1'b0;
    end

    in_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
    done_d     = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HDR;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
      n_q        <= '0;
      word_cnt_q <= '0;
      addr_q     <= BASE;
      mem_addr_q <= BASE;
      mem_req_q  <= 1'b0;
      in_ready_q <= 1'b0;
      load_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      in_ready_q <= in_ready_d;
      load_err_q <= load_err_d;
      done_q     <= done_d;
    end
  end

  // The shift register holds the finished word untouched while in WR.
  assign bus.in_ready  = in_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = shift_q;
  assign core_rst_n    = done_q;
  assign load_done     = done_q;
  assign load_err      = load_err_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Scenario bench for boot_image_loader: expected SRAM writes are queued as the
// stream is driven and checked by a write monitor as the loader issues them.
module tb_boot_image_loader;

  localparam int ADDR_W = 12;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic core_rst_n, load_done, load_err;

  boot_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

  boot_image_loader #(.ADDR_W(ADDR_W), .BASE(12'h000), .DEPTH(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  wr_t exp_q[$];
  wr_t mon_e;

  // A write seen with req&&ready at the falling edge is accepted at the next rise.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.mem_req === 1'b1 && bus.mem_ready === 1'b1) begin
      wr_count++;
      last_addr = bus.mem_addr;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_write: got addr=%h data=%h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, mon_e.addr, mon_e.data}) begin
          n_bad++;
          $display("FAIL sb_write: got we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  function automatic logic [31:0] pat(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Returns #1 after the edge at which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_byte_timeout: in_ready=%b, required 1 within 50 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    bus.mem_ready = v;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (load_done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if ({load_done, core_rst_n, bus.in_ready, bus.mem_req} !== 4'b1100) begin
      n_bad++;
      $display("FAIL %s_done: got done=%b core_rst_n=%b in_ready=%b req=%b, required 1 1 0 0",
               name, load_done, core_rst_n, bus.in_ready, bus.mem_req);
    end
  endtask

  task automatic check_sb_empty(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_sb_empty: %0d writes still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.mem_req, bus.mem_we, core_rst_n, load_done, load_err,
         bus.mem_addr, bus.mem_wdata} !== {6'b0, 12'h000, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b req=%b we=%b crst=%b done=%b err=%b addr=%h wd=%h, required all 0",
               bus.in_ready, bus.mem_req, bus.mem_we, core_rst_n, load_done, load_err,
               bus.mem_addr, bus.mem_wdata);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.mem_req, core_rst_n} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_held: got rdy=%b req=%b crst=%b, required 0 0 0",
               bus.in_ready, bus.mem_req, core_rst_n);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.mem_req, core_rst_n, load_done} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_release: got rdy=%b req=%b crst=%b done=%b, required 1 0 0 0",
               bus.in_ready, bus.mem_req, core_rst_n, load_done);
    end
  endtask

  task automatic test_basic_load();
    push_exp(12'h000, 32'h0000_0013);
    push_exp(12'h001, 32'h0010_0093);
    send_word(32'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    // Fourth byte accepted at edge k: request must already be up.
    n_cmp++;
    if ({bus.mem_req, bus.in_ready, bus.mem_addr, bus.mem_wdata} !== {2'b10, 12'h000, 32'h13}) begin
      n_bad++;
      $display("FAIL basic_req_latency: got req=%b rdy=%b addr=%h wd=%h, required 1 0 000 00000013",
               bus.mem_req, bus.in_ready, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.mem_req, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_after_accept: got req=%b rdy=%b, required 0 1", bus.mem_req, bus.in_ready);
    end
    send_word(32'h0010_0093);
    wait_done("basic");
    check_sb_empty("basic");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, load_done} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_backpressure: got rdy=%b done=%b, required 0 1", bus.in_ready, load_done);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_zero_header();
    int base;
    pulse_restart();
    n_cmp++;
    if ({load_done, core_rst_n, load_err, bus.in_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL zero_restart: got done=%b crst=%b err=%b rdy=%b, required 0 0 0 1",
               load_done, core_rst_n, load_err, bus.in_ready);
    end
    base = wr_count;
    send_word(32'd0);
    n_cmp++;
    if ({load_done, core_rst_n, bus.mem_req} !== 3'b110) begin
      n_bad++;
      $display("FAIL zero_done: got done=%b crst=%b req=%b, required 1 1 0",
               load_done, core_rst_n, bus.mem_req);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wr_count != base || bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_no_write: got %0d writes req=%b, required 0 writes req=0",
               wr_count - base, bus.mem_req);
    end
  endtask

  task automatic test_stall();
    pulse_restart();
    set_ready(1'b0);
    push_exp(12'h000, 32'hDEAD_BEEF);
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_req, bus.in_ready, bus.mem_addr, bus.mem_wdata} !== {2'b10, 12'h000, 32'hDEAD_BEEF}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got req=%b rdy=%b addr=%h wd=%h, required 1 0 000 deadbeef",
                 i, bus.mem_req, bus.in_ready, bus.mem_addr, bus.mem_wdata);
      end
    end
    set_ready(1'b1);
    wait_done("stall");
    check_sb_empty("stall");
  endtask

  task automatic test_overflow();
    int base;
    pulse_restart();
    base = wr_count;
    for (int i = 0; i < 4096; i++) push_exp(12'(i), pat(i));
    send_word(32'h0000_2000);
    n_cmp++;
    if (load_err !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_err: got load_err=%b, required 1", load_err);
    end
    for (int i = 0; i < 4096; i++) send_word(pat(i));
    wait_done("overflow");
    check_sb_empty("overflow");
    n_cmp++;
    if (wr_count - base != 4096 || last_addr !== 12'hFFF || bus.mem_addr !== 12'hFFF || load_err !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_count: got writes=%0d last=%h addr=%h err=%b, required 4096 fff fff 1",
               wr_count - base, last_addr, bus.mem_addr, load_err);
    end
  endtask

  task automatic test_restart_mid_data();
    pulse_restart();
    send_word(32'h0000_1001);
    n_cmp++;
    if (load_err !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_pre_err: got load_err=%b, required 1", load_err);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_restart();
    n_cmp++;
    if ({load_err, core_rst_n, load_done, bus.in_ready, bus.mem_req} !== 5'b00010) begin
      n_bad++;
      $display("FAIL restart_state: got err=%b crst=%b done=%b rdy=%b req=%b, required 0 0 0 1 0",
               load_err, core_rst_n, load_done, bus.in_ready, bus.mem_req);
    end
    push_exp(12'h000, 32'hCAFE_F00D);
    send_word(32'd1);
    n_cmp++;
    if ({load_err, load_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL restart_new_hdr: got err=%b done=%b, required 0 0", load_err, load_done);
    end
    send_word(32'hCAFE_F00D);
    wait_done("restart");
    check_sb_empty("restart");
  endtask

  task automatic test_restart_in_write();
    int base;
    pulse_restart();
    set_ready(1'b0);
    send_word(32'd1);
    send_word(32'h1234_5678);
    base = wr_count;
    pulse_restart();
    n_cmp++;
    if ({bus.mem_req, bus.in_ready, load_done, core_rst_n} !== 4'b0100) begin
      n_bad++;
      $display("FAIL restart_wr_drop: got req=%b rdy=%b done=%b crst=%b, required 0 1 0 0",
               bus.mem_req, bus.in_ready, load_done, core_rst_n);
    end
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_count != base) begin
      n_bad++;
      $display("FAIL restart_wr_none: got %0d writes, required 0", wr_count - base);
    end
    check_sb_empty("restart_wr");
  endtask

  task automatic test_async_reset();
    set_ready(1'b0);
    pulse_restart();
    send_word(32'd1);
    send_word(32'h0BAD_F00D);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req, bus.in_ready, core_rst_n} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_rst: got req=%b rdy=%b crst=%b, required 0 0 0",
               bus.mem_req, bus.in_ready, core_rst_n);
    end
    @(negedge clk);
    rst = 1'b1;
    set_ready(1'b1);
    push_exp(12'h000, 32'h600D_600D);
    send_word(32'd1);
    send_word(32'h600D_600D);
    wait_done("async_reload");
    check_sb_empty("async_reload");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.mem_ready = 1'b1;
    test_reset();
    test_basic_load();
    test_zero_header();
    test_stall();
    test_overflow();
    test_restart_mid_data();
    test_restart_in_write();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
